// File: rtl/simd_alu_result_stage.sv
// Result stage after the SIMD adder: 2-entry skid buffer, optional 8-bit lane
// saturation (SIMD_ALU_RESULT_SAT_EN) and sticky overflow/underflow status.
module simd_alu_result_stage #(
  parameter int SIMD_DATA_WIDTH            = 256,
  parameter int SIMD_ADDER_DATA_MODE_WIDTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [SIMD_DATA_WIDTH-1:0]            in_result,
  input  logic [SIMD_DATA_WIDTH/8-1:0]          in_ovf,
  input  logic [SIMD_DATA_WIDTH/8-1:0]          in_udf,
  input  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] in_data_mode,
  input  logic                                  in_data_signed,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [SIMD_DATA_WIDTH-1:0]            out_result,
  output logic [SIMD_DATA_WIDTH/8-1:0]          out_flags,
  input  logic                                  clr_status,
  output logic                                  sticky_flag,
  output logic [15:0]                           flag_count
);

  localparam int NB = SIMD_DATA_WIDTH / 8;

  typedef struct packed {
    logic [SIMD_DATA_WIDTH-1:0]            data;
    logic [NB-1:0]                         ovf;
    logic [NB-1:0]                         udf;
    logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] mode;
    logic                                  sgn;
  } beat_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  occ_t  state, state_next;
  beat_t head, skid, in_beat;
  logic  ready_q;
  logic  accept, pop, flagged;
  logic  load_head_in, load_head_skid, load_skid;

  assign in_beat  = '{data: in_result, ovf: in_ovf, udf: in_udf,
                      mode: in_data_mode, sgn: in_data_signed};
  assign accept   = in_valid && ready_q;
  assign pop      = (state != EMPTY) && out_ready;
  assign flagged  = accept && (|(in_ovf | in_udf));

  assign in_ready  = ready_q;
  assign out_valid = (state != EMPTY);
  assign out_flags = head.ovf | head.udf;

  // head is always the oldest beat; skid only fills when head is blocked
  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      EMPTY: if (accept) begin
        state_next   = ONE;
        load_head_in = 1'b1;
      end
      ONE: begin
        if (accept && pop) begin
          load_head_in = 1'b1;
        end else if (accept) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: if (pop) begin
        state_next     = ONE;
        load_head_skid = 1'b1;
      end
      default: state_next = EMPTY;
    endcase
  end

  // in_ready is a register so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (load_head_in)        head <= in_beat;
      else if (load_head_skid) head <= skid;
      if (load_skid)           skid <= in_beat;
    end
  end

  // A flagged accept takes priority over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flag <= 1'b0;
      flag_count  <= '0;
    end else if (clr_status) begin
      sticky_flag <= flagged;
      flag_count  <= flagged ? 16'd1 : 16'd0;
    end else if (flagged) begin
      sticky_flag <= 1'b1;
      if (flag_count != 16'hFFFF) flag_count <= flag_count + 16'd1;
    end
  end

`ifdef SIMD_ALU_RESULT_SAT_EN
  always_comb begin
    out_result = head.data;
    if (head.mode == '0) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (head.ovf[i])      out_result[8*i +: 8] = head.sgn ? 8'h7F : 8'hFF;
        else if (head.udf[i]) out_result[8*i +: 8] = head.sgn ? 8'h80 : 8'h00;
      end
    end
  end
`else
  // lane mode/sign travel with the beat but only the saturating build reads them
  logic unused_cfg;
  assign unused_cfg = ^{head.mode, head.sgn};
  assign out_result = head.data;
`endif

endmodule
